dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
// - Memory-side responder for the KGPRISC data port: serves CPU load/store requests over a valid/ready
//   request channel and returns read data plus an error flag on a valid/ready response channel.
// - Sits between kgp_risc's data-access path and an internal word-organised store; replaces the
//   fixed-latency data memory when the core needs backpressure-tolerant memory timing.
// - Single outstanding request, pipelined: a new request is accepted in the same cycle as the previous response is consumed.
// PARAMETERS
// - DEPTH   256  number of 32-bit words (power of two, >= 4)
// - CNT_W   16   width of the saturating access counters
// PORTS
// - clk        in   1      single clock, all state on rising edge
// - rst_n      in   1      asynchronous, active-low reset
// - req_valid  in   1      request present
// - req_ready  out  1      responder can accept request this cycle
// - req_addr   in   32     byte address; word index = req_addr[log2(DEPTH)+1:2]
// - req_we     in   4      byte-lane write enables; 4'b0000 = load, nonzero = store
// - req_wdata  in   32     store data; lane i = req_wdata[8i+7:8i]
// - rsp_valid  out  1      response present
// - rsp_ready  in   1      consumer accepts response
// - rsp_rdata  out  32     word at address after any write in the same request
// - rsp_err    out  1      request was misaligned or out of range
// - rd_count   out  CNT_W  accepted loads, saturating
// - wr_count   out  CNT_W  accepted stores, saturating
// BEHAVIOUR
// - Reset (rst_n=0, async): rsp_valid=0, rsp_rdata=0, rsp_err=0, rd_count=0, wr_count=0, state=IDLE.
//   Memory contents are NOT cleared. A pending response is dropped. Any store accepted at an earlier edge stays committed.
// - req_ready = (state==IDLE) | rsp_ready; combinational, never depends on req_valid.
// - Accept = req_valid & req_ready at a rising edge; request fields sampled only at that edge.
// - FSM: IDLE --accept--> RESP; RESP --rsp_ready & !accept--> IDLE; RESP --rsp_ready & accept--> RESP (back-to-back).
//   RESP with !rsp_ready: hold; rsp_valid, rsp_rdata and rsp_err stay stable.
// - Latency: rsp_valid rises exactly 1 cycle after accept; back-to-back throughput 1 request/cycle.
// - Error: err = (req_addr[1:0]!=0) | (req_addr[31:2] >= DEPTH). On err: no memory write, rsp_rdata=0, rsp_err=1.
//   Counters are still updated.
// - Store (err=0): for each i with req_we[i]=1, mem[idx][8i+7:8i] <= req_wdata[8i+7:8i] at the accept edge.
//   Unselected lanes are unchanged. rsp_rdata = merged post-write word.
// - Load (err=0): rsp_rdata = mem[idx] as of the accept edge.
//   A load immediately after a store to the same word returns the stored data; no stale read.
// - Counters: rd_count += 1 on accept with req_we==0; wr_count += 1 on accept with req_we!=0.
//   Each saturates at 2^CNT_W-1 with no wrap-around.
// - Assumption: req_* may change freely while req_ready=0. X on req_* when req_valid=0 must not corrupt state.
// TESTING
// - Reset, then store addr=0x10 we=4'hF wdata=0xDEADBEEF; load 0x10 with rsp_ready=1 -> rsp_valid 1 cycle after accept,
//   rdata=0xDEADBEEF, err=0.
// - Byte lanes: word 0x20=0x11223344, store we=4'b0101 wdata=0xAABBCCDD -> rsp_rdata=0x11BB33DD; reload returns same.
// - Backpressure: hold rsp_ready=0 for 5 cycles after a load -> req_ready=0, rsp_* stable.
//   Release -> req_ready=1 same cycle; back-to-back load accepted and answered next cycle.
// - Errors: load 0x12 -> err=1, rdata=0. Store to byte address DEPTH*4=0x400 -> err=1, no memory word changes.
//   rd_count and wr_count each increment by 1.
// - Reset mid-operation: assert rst_n=0 while rsp_valid=1 & rsp_ready=0 -> rsp_valid=0 immediately.
//   The earlier committed store survives, verified by a post-reset load.
// - Saturation (CNT_W=4): 20 loads -> rd_count=15, wr_count=0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between a data-port requester and dmem_responder.
// Latency: none (wires only); timing is set by the responder.
// Backpressure: valid/ready on both the request and the response channel.
interface dmem_responder_if #(
  parameter int CNT_W = 16
) ();
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_addr;
  logic [3:0]       req_we;
  logic [31:0]      req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  // Requester side (CPU data port).
  modport master (
    output req_valid, req_addr, req_we, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rd_count, wr_count
  );

  // Responder side (memory).
  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rd_count, wr_count
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory serving load/store requests with byte-lane writes and error flagging.
// Latency: response valid 1 cycle after accept; back-to-back throughput of 1 request/cycle.
// Backpressure: one outstanding response; a new request is taken only when idle or as the response is consumed.
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;
  logic [CNT_W-1:0] rd_count_q;
  logic [CNT_W-1:0] wr_count_q;
  logic [31:0]      mem_q [DEPTH];

  logic             accept;
  logic             is_store;
  logic             req_err;
  logic [AW-1:0]    idx;
  logic [31:0]      cur_word;
  logic [31:0]      merged_word;
  logic [31:0]      rsp_rdata_d;
  logic [CNT_W-1:0] rd_count_d;
  logic [CNT_W-1:0] wr_count_d;

  // Ready never looks at req_valid, so the requester may wait on it freely.
  assign bus.req_ready = (state_q == IDLE) | bus.rsp_ready;
  assign accept        = bus.req_valid & bus.req_ready;
  assign is_store      = |bus.req_we;
  assign idx           = bus.req_addr[AW+1:2];
  // DEPTH is a power of two, so out-of-range means any address bit above the index is set.
  assign req_err       = (|bus.req_addr[1:0]) | (|bus.req_addr[31:AW+2]);
  assign cur_word      = mem_q[idx];

  // Overlay enabled byte lanes on the current word; with no lanes enabled this is the plain read.
  always_comb begin
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_we[i]) merged_word[8*i +: 8] = bus.req_wdata[8*i +: 8];
    end
  end

  // Next response data and saturating counter values for an accepted request.
  always_comb begin
    rsp_rdata_d = req_err ? 32'h0 : merged_word;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    if (is_store) begin
      if (wr_count_q != {CNT_W{1'b1}}) wr_count_d = wr_count_q + CNT_W'(1);
    end else begin
      if (rd_count_q != {CNT_W{1'b1}}) rd_count_d = rd_count_q + CNT_W'(1);
    end
  end

  // Storage array is not reset; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && accept && is_store && !req_err) mem_q[idx] <= merged_word;
  end

  // Response FSM: holds the response until consumed, reloads on a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        state_q     <= RESP;
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rsp_rdata_d;
        rsp_err_q   <= req_err;
      end else if ((state_q == RESP) && bus.rsp_ready) begin
        state_q     <= IDLE;
        rsp_valid_q <= 1'b0;
      end
    end
  end

  // Access counters advance on every accept, erroneous or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else if (accept) begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rd_count  = rd_count_q;
  assign bus.wr_count  = wr_count_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic against a memory model.
// Latency: model expects each response exactly one cycle after its accept.
// Backpressure: randomized rsp_ready; request acceptance is predicted from the model's pending state.
module tb_dmem_responder;
  localparam int DEPTH   = 256;
  localparam int CNT_W   = 16;
  localparam int AW      = $clog2(DEPTH);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.CNT_W(CNT_W)) bus ();
  dmem_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Small-counter instance used only for the saturation scenario.
  dmem_responder_if #(.CNT_W(4)) sbus ();
  dmem_responder #(.DEPTH(16), .CNT_W(4)) u_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));

  // Behavioural model state.
  logic [31:0] mem_m [DEPTH];
  logic        exp_pend;
  logic [31:0] exp_rdata;
  logic        exp_err;
  int          exp_rd;
  int          exp_wr;
  logic        checking;
  int          n_checks;
  int          n_fail;
  logic        acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one accepted request to the model: error rule, lane merge, counters.
  function automatic void model_accept(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    logic        err;
    logic [31:0] w;
    err = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    if (we == 4'h0) begin
      if (exp_rd < CNT_MAX) exp_rd = exp_rd + 1;
    end else begin
      if (exp_wr < CNT_MAX) exp_wr = exp_wr + 1;
    end
    if (err) begin
      exp_rdata = 32'h0;
      exp_err   = 1'b1;
    end else begin
      w = mem_m[a[AW+1:2]];
      for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
      mem_m[a[AW+1:2]] = w;
      exp_rdata = w;
      exp_err   = 1'b0;
    end
    exp_pend = 1'b1;
  endfunction

  // Compare process: outputs vs model every cycle while out of reset.
  always @(negedge clk) begin
    if (checking && rst_n) begin
      chk("rsp_valid", bus.rsp_valid, exp_pend);
      if (exp_pend) begin
        chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
        chk("rsp_err", bus.rsp_err, exp_err);
      end
      chk("rd_count", bus.rd_count, 64'(exp_rd));
      chk("wr_count", bus.wr_count, 64'(exp_wr));
    end
  end

  // One bus cycle: drive inputs mid-cycle, predict ready/accept, advance the model.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [3:0] we,
                       input logic [31:0] wd, input logic rr, output logic accepted);
    logic model_ready;
    @(negedge clk); #1;
    bus.req_valid = v;
    bus.req_addr  = v ? a  : $urandom();
    bus.req_we    = v ? we : 4'($urandom());
    bus.req_wdata = v ? wd : $urandom();
    bus.rsp_ready = rr;
    #1;
    model_ready = !exp_pend || rr;
    chk("req_ready", bus.req_ready, model_ready);
    accepted = v && model_ready;
    if (exp_pend && rr) exp_pend = 1'b0;
    if (accepted) model_accept(a, we, wd);
  endtask

  task automatic req1(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    logic a_ok;
    cycle(1'b1, a, we, wd, 1'b1, a_ok);
  endtask

  task automatic idle(input logic rr);
    logic a_ok;
    cycle(1'b0, 32'h0, 4'h0, 32'h0, rr, a_ok);
  endtask

  task automatic do_reset(input bit mid);
    @(negedge clk); #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    rst_n    = 1'b0;
    exp_pend = 1'b0;
    exp_rd   = 0;
    exp_wr   = 0;
    #1;
    if (mid) begin
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_rd_count", bus.rd_count, 16'h0);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int r0;
    int w0;
    n_checks = 0; n_fail = 0; checking = 1'b0;
    exp_pend = 1'b0; exp_rd = 0; exp_wr = 0; exp_rdata = 32'h0; exp_err = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = 32'h0; bus.req_we = 4'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
    sbus.req_valid = 1'b0; sbus.req_addr = 32'h0; sbus.req_we = 4'h0; sbus.req_wdata = 32'h0; sbus.rsp_ready = 1'b1;

    // Power-on reset values.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset_rsp_err", bus.rsp_err, 1'b0);
    chk("reset_rd_count", bus.rd_count, 16'h0);
    chk("reset_wr_count", bus.wr_count, 16'h0);
    @(negedge clk); #1 rst_n = 1'b1;
    checking = 1'b1;

    // Give every word a known value, then reset to clear the counters (memory must survive).
    for (int i = 0; i < DEPTH; i++) req1(32'(i) << 2, 4'hF, $urandom());
    do_reset(1'b0);

    // Full-word store then load.
    req1(32'h10, 4'hF, 32'hDEADBEEF);
    req1(32'h10, 4'h0, 32'h0);
    idle(1'b1);
    chk("load_valid", bus.rsp_valid, 1'b1);
    chk("load_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("load_err", bus.rsp_err, 1'b0);

    // Byte-lane merge.
    req1(32'h20, 4'hF, 32'h11223344);
    req1(32'h20, 4'b0101, 32'hAABBCCDD);
    idle(1'b1);
    chk("lane_store_rdata", bus.rsp_rdata, 32'h11BB33DD);
    req1(32'h20, 4'h0, 32'h0);
    idle(1'b1);
    chk("lane_reload_rdata", bus.rsp_rdata, 32'h11BB33DD);

    // Backpressure: response held for 5 cycles, then released with a back-to-back load.
    req1(32'h20, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h10, 4'h0, 32'h0, 1'b0, acc);
      chk("bp_req_ready", bus.req_ready, 1'b0);
      chk("bp_hold_rdata", bus.rsp_rdata, 32'h11BB33DD);
    end
    cycle(1'b1, 32'h10, 4'h0, 32'h0, 1'b1, acc);
    chk("bp_release_ready", bus.req_ready, 1'b1);
    idle(1'b1);
    chk("bp_b2b_valid", bus.rsp_valid, 1'b1);
    chk("bp_b2b_rdata", bus.rsp_rdata, 32'hDEADBEEF);

    // Error cases: misaligned load and out-of-range store.
    r0 = exp_rd; w0 = exp_wr;
    req1(32'h12, 4'h0, 32'h0);
    idle(1'b1);
    chk("mis_err", bus.rsp_err, 1'b1);
    chk("mis_rdata", bus.rsp_rdata, 32'h0);
    req1(32'h400, 4'hF, 32'hFFFFFFFF);
    idle(1'b1);
    chk("oor_err", bus.rsp_err, 1'b1);
    chk("oor_rdata", bus.rsp_rdata, 32'h0);
    chk("err_rd_inc", bus.rd_count, 64'(r0 + 1));
    chk("err_wr_inc", bus.wr_count, 64'(w0 + 1));
    req1(32'h0, 4'h0, 32'h0);
    req1(32'h10, 4'h0, 32'h0);
    idle(1'b1);
    chk("oor_no_write", bus.rsp_rdata, 32'hDEADBEEF);

    // Reset while a response is held.
    req1(32'h20, 4'h0, 32'h0);
    idle(1'b0);
    chk("pre_rst_valid", bus.rsp_valid, 1'b1);
    do_reset(1'b1);
    req1(32'h20, 4'h0, 32'h0);
    idle(1'b1);
    chk("post_rst_rdata", bus.rsp_rdata, 32'h11BB33DD);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      logic [3:0]  we;
      int          sel;
      sel = $urandom_range(0, 19);
      if (sel == 0)      a = $urandom();
      else if (sel == 1) a = (32'($urandom_range(0, DEPTH-1)) << 2) | 32'($urandom_range(1, 3));
      else               a = 32'($urandom_range(0, DEPTH-1)) << 2;
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      cycle($urandom_range(0, 9) < 7, a, we, $urandom(), $urandom_range(0, 9) < 7, acc);
    end
    idle(1'b1);
    idle(1'b1);

    // Saturation on the 4-bit counter instance: 20 loads.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (i == 10) chk("sat_rd_mid", sbus.rd_count, 4'd10);
      if (i == 15) chk("sat_rd_at_max", sbus.rd_count, 4'd15);
      sbus.req_valid = 1'b1;
      sbus.req_addr  = 32'(i % 16) << 2;
      sbus.req_we    = 4'h0;
      sbus.req_wdata = 32'h0;
    end
    @(negedge clk); #1;
    sbus.req_valid = 1'b0;
    chk("sat_rd_final", sbus.rd_count, 4'd15);
    chk("sat_wr_final", sbus.wr_count, 4'd0);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
